// File: rtl/relogio_pkg.sv
// Shared types and constants for the clock/alarm blocks.
// State encoding, BCD limits and the binary-to-BCD helper used for reset values.
package relogio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarme_st_t;

  localparam int HORA_MAX = 23;
  localparam int MIN_MAX  = 59;

  // Returns {tens, units}, each a 4-bit BCD digit (valid for 0..99).
  function automatic logic [7:0] bin2bcd(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'((v / 10) % 10);
    units = 4'(v % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/inc_bcd_par.sv
// BCD tens/units register pair that increments by one and wraps MAX -> 00.
// Latency 1 (updates on the clock after inc); no backpressure, inc is a plain pulse.
module inc_bcd_par
  import relogio_pkg::*;
#(
  parameter int MAX     = 59,
  parameter int MSD_W   = 3,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [MSD_W-1:0] msd,
  output logic [3:0]       lsd
);

  localparam logic [7:0] RST_BCD = bin2bcd(RST_VAL);
  localparam logic [7:0] MAX_BCD = bin2bcd(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msd <= RST_BCD[4 +: MSD_W];
      lsd <= RST_BCD[3:0];
    end else if (inc) begin
      if ({4'(msd), lsd} == MAX_BCD) begin
        msd <= '0;
        lsd <= '0;
      end else if (lsd == 4'd9) begin
        msd <= msd + 1'b1;
        lsd <= '0;
      end else begin
        lsd <= lsd + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarme_despertador.sv
// Alarm stage: stores the alarm time, compares it with the running clock, rings the buzzer.
// Latency: ringing rises 1 cycle after the match edge; no backpressure. SNOOZE_EN adds snooze.
module alarme_despertador
  import relogio_pkg::*;
#(
  parameter int RING_SECONDS = 60,
  parameter int SNOOZE_MIN   = 5,
  parameter int ALARM_H_RST  = 6,
  parameter int ALARM_M_RST  = 0
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable_1hz,
  input  logic [1:0] bcd_h_msd,
  input  logic [3:0] bcd_h_lsd,
  input  logic [2:0] bcd_m_msd,
  input  logic [3:0] bcd_m_lsd,
  input  logic [2:0] bcd_s_msd,
  input  logic [3:0] bcd_s_lsd,
  input  logic       alarm_on,
  input  logic       btn_set,
  input  logic       btn_inc_h,
  input  logic       btn_inc_m,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic [1:0] al_h_msd,
  output logic [3:0] al_h_lsd,
  output logic [2:0] al_m_msd,
  output logic [3:0] al_m_lsd,
  output logic       ringing,
  output logic       buzzer
);

  localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);
  localparam logic [9:0] SNZ_TICKS = 10'(SNOOZE_MIN * 60);

  inc_bcd_par #(.MAX(HORA_MAX), .MSD_W(2), .RST_VAL(ALARM_H_RST)) u_inc_h (
    .clk   (CLOCK_50),
    .rst_n (reset),
    .inc   (btn_set & btn_inc_h),
    .msd   (al_h_msd),
    .lsd   (al_h_lsd)
  );

  inc_bcd_par #(.MAX(MIN_MAX), .MSD_W(3), .RST_VAL(ALARM_M_RST)) u_inc_m (
    .clk   (CLOCK_50),
    .rst_n (reset),
    .inc   (btn_set & btn_inc_m),
    .msd   (al_m_msd),
    .lsd   (al_m_lsd)
  );

  logic match;
  logic match_q;
  logic trig;

  assign match = (bcd_h_msd == al_h_msd) && (bcd_h_lsd == al_h_lsd) &&
                 (bcd_m_msd == al_m_msd) && (bcd_m_lsd == al_m_lsd) &&
                 (bcd_s_msd == 3'd0) && (bcd_s_lsd == 4'd0);

  // Edge of match so a held 00 second can only fire once per minute.
  assign trig = match & ~match_q;

  alarme_st_t state;
  alarme_st_t state_nxt;
  logic [7:0] ring_cnt;
  logic [7:0] ring_cnt_nxt;
  logic       beep_ph;
  logic       beep_ph_nxt;
  logic       timeout;

  assign timeout = enable_1hz && (ring_cnt == RING_LAST);

`ifdef SNOOZE_EN
  logic [9:0] snz_cnt;
  logic [9:0] snz_cnt_nxt;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      snz_cnt <= '0;
    end else begin
      snz_cnt <= snz_cnt_nxt;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = btn_snooze ^ (^SNZ_TICKS);
`endif

  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
`ifdef SNOOZE_EN
    snz_cnt_nxt  = snz_cnt;
`endif
    if (!alarm_on) begin
      state_nxt = IDLE;
    end else if (state == IDLE) begin
      state_nxt = ARMED;
    end else if (btn_set) begin
      state_nxt = ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (trig) begin
            state_nxt    = RINGING;
            ring_cnt_nxt = '0;
          end
        end
        RINGING: begin
          if (enable_1hz) begin
            ring_cnt_nxt = ring_cnt + 8'd1;
          end
          if (btn_stop || timeout) begin
            state_nxt = ARMED;
`ifdef SNOOZE_EN
          end else if (btn_snooze) begin
            state_nxt   = SNOOZE;
            snz_cnt_nxt = SNZ_TICKS;
`endif
          end
        end
`ifdef SNOOZE_EN
        SNOOZE: begin
          if (btn_stop) begin
            state_nxt = ARMED;
          end else if (snz_cnt == 10'd0) begin
            state_nxt    = RINGING;
            ring_cnt_nxt = '0;
          end else if (enable_1hz) begin
            snz_cnt_nxt = snz_cnt - 10'd1;
          end
        end
`endif
        default: state_nxt = state;
      endcase
    end

    // Beep phase restarts from silent on every entry into RINGING.
    if (state_nxt != RINGING) begin
      beep_ph_nxt = 1'b0;
    end else if ((state == RINGING) && enable_1hz) begin
      beep_ph_nxt = ~beep_ph;
    end else begin
      beep_ph_nxt = beep_ph;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ring_cnt <= '0;
      beep_ph  <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ring_cnt <= ring_cnt_nxt;
      beep_ph  <= beep_ph_nxt;
      match_q  <= match;
    end
  end

  assign ringing = (state == RINGING);
  assign buzzer  = ringing & beep_ph;

endmodule
